field_lock: RTL and testbench

Commits a falling piece into the playfield and clears completed rows. It is the write side of the 20x20 occupancy field that the collision checker reads. It owns the field register, stamps a 4x4 piece at a given position and rotation, scans for full rows, and collapses them. It reports how many rows were cleared.

---
 rtl/field_lock.sv | 163 ++++++++++++++++
 tb/tb_field_lock.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/field_lock.sv
// Write side of the playfield: stamps a rotated 4x4 piece into the occupancy
// field, then scans bottom-up and collapses every full row it finds.
module field_lock #(
    parameter int unsigned FIELD_W = 20,
    parameter int unsigned FIELD_H = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         clear,
    input  logic [15:0]                  block,
    input  logic [4:0]                   block_pos_x,
    input  logic [4:0]                   block_pos_y,
    input  logic [2:0]                   rotate,
    output logic [FIELD_W*FIELD_H-1:0]   field,
    output logic                         busy,
    output logic                         done,
    output logic [4:0]                   lines_cleared,
    output logic                         overlap
);

    localparam int unsigned RW = $clog2(FIELD_H);
    localparam int unsigned CW = $clog2(FIELD_W);

    typedef enum logic [2:0] {IDLE, STAMP, SCAN, SHIFT, DONE} state_t;

    state_t                              state_q;
    logic [FIELD_H-1:0][FIELD_W-1:0]     field_q;
    logic                                busy_q;
    logic                                done_q;
    logic [4:0]                          lines_q;
    logic                                ovl_q;
    logic [RW-1:0]                       row_q;
    logic [15:0]                         blk_q;
    logic [4:0]                          px_q;
    logic [4:0]                          py_q;
    logic [1:0]                          rot_q;

    logic [FIELD_H-1:0][FIELD_W-1:0]     stamp_field_d;
    logic                                stamp_ovl_d;
    logic [FIELD_H-1:0][FIELD_W-1:0]     shift_field_d;
    logic                                row_full;

    logic [3:0]                          src_k;
    logic [5:0]                          tgt_x;
    logic [5:0]                          tgt_y;
    logic                                unused_rot;

    assign unused_rot = rotate[2];

    // Source bit for each destination cell of the rotated 4x4 window.
    always_comb begin
        stamp_field_d = field_q;
        stamp_ovl_d   = 1'b0;
        src_k         = '0;
        tgt_x         = '0;
        tgt_y         = '0;
        for (int unsigned by = 0; by < 4; by++) begin
            for (int unsigned bx = 0; bx < 4; bx++) begin
                case (rot_q)
                    2'd0:    src_k = 4'(by * 4 + bx);
                    2'd1:    src_k = 4'(12 + by - 4 * bx);
                    2'd2:    src_k = 4'(15 - 4 * by - bx);
                    default: src_k = 4'(3 - by + 4 * bx);
                endcase
                tgt_x = 6'(px_q) + 6'(bx);
                tgt_y = 6'(py_q) + 6'(by);
                if (blk_q[src_k]) begin
                    if (tgt_x < 6'(FIELD_W) && tgt_y < 6'(FIELD_H)) begin
                        if (stamp_field_d[RW'(tgt_y)][CW'(tgt_x)])
                            stamp_ovl_d = 1'b1;
                        stamp_field_d[RW'(tgt_y)][CW'(tgt_x)] = 1'b1;
                    end else begin
                        stamp_ovl_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        shift_field_d = field_q;
        for (int unsigned rr = 0; rr < FIELD_H; rr++) begin
            if (RW'(rr) <= row_q) begin
                if (rr == 0)
                    shift_field_d[RW'(rr)] = '0;
                else
                    shift_field_d[RW'(rr)] = field_q[RW'(rr - 1)];
            end
        end
    end

    assign row_full = (field_q[row_q] == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            field_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            ovl_q   <= 1'b0;
            row_q   <= RW'(FIELD_H - 1);
            blk_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            rot_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        field_q <= '0;
                    end else if (start) begin
                        blk_q   <= block;
                        px_q    <= block_pos_x;
                        py_q    <= block_pos_y;
                        rot_q   <= rotate[1:0];
                        lines_q <= '0;
                        ovl_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= STAMP;
                    end
                end
                STAMP: begin
                    field_q <= stamp_field_d;
                    ovl_q   <= stamp_ovl_d;
                    row_q   <= RW'(FIELD_H - 1);
                    state_q <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        state_q <= SHIFT;
                    end else if (row_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_q <= row_q - RW'(1);
                    end
                end
                SHIFT: begin
                    // Row pointer stays put so the row dropped into it is rechecked.
                    field_q <= shift_field_d;
                    if (lines_q != 5'd31)
                        lines_q <= lines_q + 5'd1;
                    state_q <= SCAN;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign field         = field_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign overlap       = ovl_q;

endmodule

// File: tb/tb_field_lock.sv
// Directed bench for field_lock: stamping, rotation, row collapse, bounds,
// handshake and asynchronous reset, each against hand-computed values.
module tb_field_lock;

    localparam int unsigned N = 400;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic [15:0]   block;
    logic [4:0]    block_pos_x;
    logic [4:0]    block_pos_y;
    logic [2:0]    rotate;
    logic [N-1:0]  field;
    logic          busy;
    logic          done;
    logic [4:0]    lines_cleared;
    logic          overlap;

    int n_cmp = 0;
    int n_bad = 0;

    field_lock #(.FIELD_W(20), .FIELD_H(20)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clear         (clear),
        .block         (block),
        .block_pos_x   (block_pos_x),
        .block_pos_y   (block_pos_y),
        .rotate        (rotate),
        .field         (field),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .overlap       (overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns cycles from the start sampling edge to done (-1 if it never came)
    // and busy as seen in cycle 1; leaves the DUT in its first IDLE cycle.
    task automatic lock(input logic [15:0] b, input logic [4:0] px, input logic [4:0] py,
                        input logic [2:0] rot, output int lat, output logic busy1);
        @(negedge clk);
        block = b; block_pos_x = px; block_pos_y = py; rotate = rot; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy1 = busy;
        lat   = -1;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat != -1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    logic [N-1:0] ef;
    int           lat;
    logic         b1;
    int           dcnt;
    int           bcnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        block = '0; block_pos_x = '0; block_pos_y = '0; rotate = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_field", field, '0);
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        check("rst_lines", N'(lines_cleared), '0);
        check("rst_ovl", N'(overlap), '0);
        @(negedge clk) rst_n = 1'b1;

        // Basic square at (5,10)
        lock(16'h0033, 5'd5, 5'd10, 3'd0, lat, b1);
        ef = '0; ef[205] = 1'b1; ef[206] = 1'b1; ef[225] = 1'b1; ef[226] = 1'b1;
        check("sq_busy_c1", N'(b1), N'(1));
        check("sq_lat", N'(lat), N'(22));
        check("sq_field", field, ef);
        check("sq_lines", N'(lines_cleared), '0);
        check("sq_ovl", N'(overlap), '0);
        check("sq_busy_after", N'(busy), '0);

        do_clear();
        check("clr_field", field, '0);

        // Rotation 1, then 5 (same modulo 4)
        ef = '0; ef[3] = 1'b1; ef[23] = 1'b1; ef[43] = 1'b1; ef[63] = 1'b1;
        lock(16'h000F, 5'd0, 5'd0, 3'd1, lat, b1);
        check("rot1_field", field, ef);
        check("rot1_ovl", N'(overlap), '0);
        do_clear();
        lock(16'h000F, 5'd0, 5'd0, 3'd5, lat, b1);
        check("rot5_field", field, ef);

        // Fill bottom row, final lock collapses it
        do_clear();
        for (int i = 0; i < 4; i++) begin
            lock(16'h000F, 5'(4 * i), 5'd19, 3'd0, lat, b1);
            check("fill_lat", N'(lat), N'(22));
            check("fill_lines", N'(lines_cleared), '0);
        end
        lock(16'h000F, 5'd16, 5'd19, 3'd0, lat, b1);
        check("clr1_lat", N'(lat), N'(24));
        check("clr1_lines", N'(lines_cleared), N'(1));
        check("clr1_field", field, '0);

        // Same with a cell preplaced at (0,18)
        do_clear();
        lock(16'h0001, 5'd0, 5'd18, 3'd0, lat, b1);
        check("pre_lat", N'(lat), N'(22));
        for (int i = 0; i < 4; i++)
            lock(16'h000F, 5'(4 * i), 5'd19, 3'd0, lat, b1);
        lock(16'h000F, 5'd16, 5'd19, 3'd0, lat, b1);
        ef = '0; ef[380] = 1'b1;
        check("drop_lat", N'(lat), N'(24));
        check("drop_lines", N'(lines_cleared), N'(1));
        check("drop_field", field, ef);

        // Right edge overflow, then relock on top of itself
        do_clear();
        lock(16'h000F, 5'd18, 5'd0, 3'd0, lat, b1);
        ef = '0; ef[18] = 1'b1; ef[19] = 1'b1;
        check("oob_field", field, ef);
        check("oob_ovl", N'(overlap), N'(1));
        check("oob_lat", N'(lat), N'(22));
        lock(16'h000F, 5'd18, 5'd0, 3'd0, lat, b1);
        check("relock_field", field, ef);
        check("relock_ovl", N'(overlap), N'(1));

        // start while busy is ignored
        do_clear();
        @(negedge clk);
        block = 16'h0001; block_pos_x = 5'd0; block_pos_y = 5'd0; rotate = 3'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) begin
                start = 1'b1; block_pos_x = 5'd3; block_pos_y = 5'd3;
            end
            if (n == 5) start = 1'b0;
            if (done) dcnt++;
        end
        ef = '0; ef[0] = 1'b1;
        check("hs_done_cnt", N'(dcnt), N'(1));
        check("hs_field", field, ef);
        check("hs_busy", N'(busy), '0);

        // start and clear together: clear wins, no operation
        @(negedge clk);
        block = 16'h0033; block_pos_x = 5'd5; block_pos_y = 5'd10; start = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; clear = 1'b0; end
        check("sc_field", field, '0);
        dcnt = 0; bcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("sc_done_cnt", N'(dcnt), '0);
        check("sc_busy_cnt", N'(bcnt), '0);

        // Asynchronous reset in the middle of SCAN
        @(negedge clk);
        block = 16'h000F; block_pos_x = 5'd18; block_pos_y = 5'd0; rotate = 3'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ef = '0; ef[18] = 1'b1; ef[19] = 1'b1;
        check("mid_field", field, ef);
        check("mid_busy", N'(busy), N'(1));
        check("mid_ovl", N'(overlap), N'(1));
        rst_n = 1'b0;
        #1;
        check("arst_field", field, '0);
        check("arst_busy", N'(busy), '0);
        check("arst_done", N'(done), '0);
        check("arst_lines", N'(lines_cleared), '0);
        check("arst_ovl", N'(overlap), '0);
        @(negedge clk) rst_n = 1'b1;
        lock(16'h0033, 5'd5, 5'd10, 3'd0, lat, b1);
        ef = '0; ef[205] = 1'b1; ef[206] = 1'b1; ef[225] = 1'b1; ef[226] = 1'b1;
        check("post_lat", N'(lat), N'(22));
        check("post_field", field, ef);
        check("post_ovl", N'(overlap), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
